// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: reset PC, NOP word, FSM states, skid entry.
package if_fetch_pkg;

  localparam logic [29:0] RESET_PC_DEFAULT = 30'h0000_0C00;
  localparam logic [31:0] NOP_INS          = 32'h0000_0000;

  typedef enum logic [1:0] {
    IfReq   = 2'd0,
    IfFull  = 2'd1,
    IfDrain = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0] ins;
    logic [29:0] pc;
  } if_entry_t;

endpackage

// File: rtl/if_fetch_skid.sv
// One-entry holding buffer for an instruction acked while ID is stalled.
module if_fetch_skid
  import if_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  logic      unload_i,
  input  logic      clear_i,
  input  if_entry_t data_i,
  output if_entry_t data_o,
  output logic      full_o
);

  if_entry_t data_q;
  logic      full_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      full_q <= 1'b0;
    end else begin
      if (clear_i || unload_i) begin
        full_q <= 1'b0;
      end else if (load_i) begin
        full_q <= 1'b1;
      end
      if (load_i && !clear_i) begin
        data_q <= data_i;
      end
    end
  end

  assign data_o = data_q;
  assign full_o = full_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC, imem req/ack handshake, skid for ID stalls, redirect draining.
// Optional macro IF_NOP_INSERT_EN forces IF_ins to a NOP whenever if_valid is low.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [29:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [29:0] redirect_pc,
  output logic [31:0] IF_ins,
  output logic [29:0] PC,
  output logic        if_valid
);

  if_state_e   state_q, state_d;
  logic [29:0] pc_q, pc_d;
  logic [29:0] drain_addr_q, drain_addr_d;
  logic [31:0] ins_q, ins_d;
  logic [29:0] opc_q, opc_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;

  logic        ack, consume;
  logic        skid_load, skid_unload, skid_clear, skid_full;
  if_entry_t   skid_in, skid_out;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack     = imem_ack & req_q;
  assign consume = valid_q & ~stall;
  assign skid_in = '{ins: imem_rdata, pc: pc_q};

  if_fetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load_i   (skid_load),
    .unload_i (skid_unload),
    .clear_i  (skid_clear),
    .data_i   (skid_in),
    .data_o   (skid_out),
    .full_o   (skid_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IfReq;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      ins_q        <= '0;
      opc_q        <= '0;
      valid_q      <= 1'b0;
      req_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      ins_q        <= ins_d;
      opc_q        <= opc_d;
      valid_q      <= valid_d;
      req_q        <= req_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    ins_d        = ins_q;
    opc_d        = opc_q;
    valid_d      = valid_q;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    if (redirect) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      pc_d       = redirect_pc;
      unique case (state_q)
        IfReq: begin
          // Request still outstanding: keep presenting its address until the ack drains it.
          if (!ack) begin
            state_d      = IfDrain;
            drain_addr_d = pc_q;
          end
        end
        IfFull:  state_d = IfReq;
        IfDrain: if (ack) state_d = IfReq;
        default: state_d = IfReq;
      endcase
    end else begin
      unique case (state_q)
        IfReq: begin
          if (ack) begin
            pc_d = pc_q + 30'd1;
            if (!valid_q || consume) begin
              ins_d   = imem_rdata;
              opc_d   = pc_q;
              valid_d = 1'b1;
            end else begin
              skid_load = 1'b1;
              state_d   = IfFull;
            end
          end else if (consume) begin
            valid_d = 1'b0;
          end
        end
        IfFull: begin
          if (consume) begin
            ins_d       = skid_out.ins;
            opc_d       = skid_out.pc;
            skid_unload = 1'b1;
            state_d     = IfReq;
          end
        end
        IfDrain: begin
          if (ack) state_d = IfReq;
          if (consume) valid_d = 1'b0;
        end
        default: state_d = IfReq;
      endcase
    end
    req_d = (state_d != IfFull);
  end

  always_comb begin
    imem_req  = req_q;
    imem_addr = (state_q == IfDrain) ? drain_addr_q : pc_q;
    PC        = opc_q;
    if_valid  = valid_q;
`ifdef IF_NOP_INSERT_EN
    IF_ins    = valid_q ? ins_q : NOP_INS;
`else
    IF_ins    = ins_q;
`endif
  end

  logic unused_skid_full;
  assign unused_skid_full = skid_full;

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: scoreboard of delivered instructions plus handshake/flush checks.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [29:0] redirect_pc;
  logic [31:0] IF_ins;
  logic [29:0] PC;
  logic        if_valid;

  int errs   = 0;
  int checks = 0;
  logic [61:0] sb[$];

  if_fetch dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .IF_ins      (IF_ins),
    .PC          (PC),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, score any consume, advance to the next negedge.
  task automatic cyc(input bit a, input bit st, input bit rd, input logic [29:0] rpc,
                     input bit keep);
    logic [61:0] e;
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = a & imem_req;
    imem_rdata  = pat(imem_addr);
    if (imem_ack && keep && !rd) sb.push_back({imem_addr, pat(imem_addr)});
    if (rd) begin
      sb.delete();
    end else if (if_valid && !st) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", {63'd0, if_valid}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("out_pc", {34'd0, PC}, {34'd0, e[61:32]});
        chk("out_ins", {32'd0, IF_ins}, {32'd0, e[31:0]});
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, if_valid}, 64'd0);
    chk("rst_ins", {32'd0, IF_ins}, 64'd0);
    chk("rst_pc", {34'd0, PC}, 64'd0);
    chk("rst_req", {63'd0, imem_req}, 64'd0);

    rst = 1'b0;
    @(negedge clk);
    chk("first_req", {63'd0, imem_req}, 64'd1);
    chk("first_valid", {63'd0, if_valid}, 64'd0);

    // Back-to-back acks: one instruction per cycle.
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", {34'd0, imem_addr}, {34'd0, 30'h0C00 + 30'(i)});
      cyc(1, 0, 0, '0, 1);
      chk("seq_valid", {63'd0, if_valid}, 64'd1);
    end

    // Stall for three cycles: ack on 0xC04 goes to skid, request drops.
    cyc(1, 1, 0, '0, 1);
    chk("full_req0", {63'd0, imem_req}, 64'd0);
    cyc(1, 1, 0, '0, 1);
    chk("full_req1", {63'd0, imem_req}, 64'd0);
    chk("stall_pc", {34'd0, PC}, {34'd0, 30'h0C03});
    cyc(0, 1, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    chk("unstall_req", {63'd0, imem_req}, 64'd1);
    chk("unstall_addr", {34'd0, imem_addr}, {34'd0, 30'h0C05});
    chk("skid_out_pc", {34'd0, PC}, {34'd0, 30'h0C04});

    // Consume without refill, then redirect while 0xC05 is outstanding.
    cyc(0, 0, 0, '0, 1);
    chk("bubble_valid", {63'd0, if_valid}, 64'd0);
    chk("bubble_pc_hold", {34'd0, PC}, {34'd0, 30'h0C04});
    cyc(0, 0, 1, 30'h100, 0);
    chk("drain_addr0", {34'd0, imem_addr}, {34'd0, 30'h0C05});
    chk("drain_req", {63'd0, imem_req}, 64'd1);
    cyc(0, 0, 0, '0, 0);
    chk("drain_addr1", {34'd0, imem_addr}, {34'd0, 30'h0C05});
    cyc(1, 0, 0, '0, 0);
    chk("drain_valid", {63'd0, if_valid}, 64'd0);
    chk("target_addr", {34'd0, imem_addr}, {34'd0, 30'h100});
    cyc(1, 0, 0, '0, 1);
    chk("target_valid", {63'd0, if_valid}, 64'd1);
    chk("target_next", {34'd0, imem_addr}, {34'd0, 30'h101});

    // Redirect with a same-cycle ack: acked data is dropped.
    cyc(1, 0, 1, 30'h200, 0);
    chk("rdack_valid", {63'd0, if_valid}, 64'd0);
    chk("rdack_addr", {34'd0, imem_addr}, {34'd0, 30'h200});
    chk("rdack_pc_hold", {34'd0, PC}, {34'd0, 30'h100});
`ifdef IF_NOP_INSERT_EN
    chk("flush_ins", {32'd0, IF_ins}, 64'd0);
`else
    chk("flush_ins", {32'd0, IF_ins}, {32'd0, pat(30'h100)});
`endif
    cyc(1, 0, 0, '0, 1);
    chk("r200_valid", {63'd0, if_valid}, 64'd1);

    // Redirect together with stall: flush wins, request 0x201 drains.
    cyc(0, 1, 1, 30'h3FFF_FFFF, 0);
    chk("rdstall_valid", {63'd0, if_valid}, 64'd0);
    chk("rdstall_addr", {34'd0, imem_addr}, {34'd0, 30'h201});
    cyc(1, 0, 0, '0, 0);
    chk("wrap_addr0", {34'd0, imem_addr}, {34'd0, 30'h3FFF_FFFF});
    cyc(1, 0, 0, '0, 1);
    chk("wrap_addr1", {34'd0, imem_addr}, 64'd0);
    cyc(1, 0, 0, '0, 1);
    chk("wrap_addr2", {34'd0, imem_addr}, 64'd1);
    cyc(0, 0, 0, '0, 0);
    chk("end_valid", {63'd0, if_valid}, 64'd0);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
